// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: access mode codes, FSM
// state encoding and small mode-classification helpers.
package mem_responder_pkg;

  // CPU-side access modes
  localparam logic [3:0] IO_NOP = 4'd0;
  localparam logic [3:0] IO_LW  = 4'd1;
  localparam logic [3:0] IO_LB  = 4'd2;
  localparam logic [3:0] IO_SW  = 4'd3;
  localparam logic [3:0] IO_SB  = 4'd4;

  // All byte lanes disabled (active-low)
  localparam logic [3:0] BE_NONE = 4'hF;

  // Responder FSM states
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  // Only the four defined access codes start an access; NOP and
  // unassigned codes are ignored.
  function automatic logic is_access(input logic [3:0] m);
    return (m == IO_LW) || (m == IO_LB) || (m == IO_SW) || (m == IO_SB);
  endfunction

  function automatic logic is_read(input logic [3:0] m);
    return (m == IO_LW) || (m == IO_LB);
  endfunction

  // Word accesses must be 4-byte aligned
  function automatic logic is_word(input logic [3:0] m);
    return (m == IO_LW) || (m == IO_SW);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU <-> responder request/response bundle.
interface mem_responder_if;
  logic        req;
  logic [3:0]  mem_mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        align_err;

  // CPU datapath side
  modport master (
    output req, mem_mode, addr, wdata,
    input  rdata, busy, done, align_err
  );

  // Responder side
  modport slave (
    input  req, mem_mode, addr, wdata,
    output rdata, busy, done, align_err
  );
endinterface

// File: rtl/mem_byte_lane.sv
// Little-endian byte-lane steering: byte enables and replicated store data
// for writes, byte extract with sign extension for LB loads.
module mem_byte_lane
  import mem_responder_pkg::*;
(
  input  logic [3:0]  mode,
  input  logic [1:0]  boff,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be_n,
  output logic [31:0] wdata_out,
  output logic [31:0] ld_data
);

  logic [7:0] ld_byte;

  // SB drives one lane with the byte replicated on all four; everything
  // else uses the whole word.
  always_comb begin
    be_n      = 4'h0;
    wdata_out = wdata;
    if (mode == IO_SB) begin
      be_n      = ~(4'b0001 << boff);
      wdata_out = {4{wdata[7:0]}};
    end
  end

  // LB picks the addressed byte and sign-extends; LW passes the word.
  always_comb begin
    ld_byte = rword[8*boff +: 8];
    ld_data = rword;
    if (mode == IO_LB) ld_data = {{24{ld_byte[7]}}, ld_byte};
  end

endmodule

// File: rtl/mem_responder.sv
// Memory request responder: runs CPU loads/stores against an external
// asynchronous 32-bit SRAM with WAIT_CYCLES extra strobe cycles. All pad
// strobes are registered so they are glitch-free and drop on reset.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_responder_if.slave     bus,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_dq_o,
  input  logic [31:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_e             state_q, state_d;
  logic [3:0]         mode_q, mode_d;
  logic [1:0]         boff_q, boff_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               aerr_q, aerr_d;
  logic [SRAM_AW-1:0] saddr_q, saddr_d;
  logic [31:0]        dq_o_q, dq_o_d;
  logic               dq_oe_q, dq_oe_d;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  logic [3:0]         be_n_q, be_n_d;

  logic [3:0]         lane_mode;
  logic [1:0]         lane_off;
  logic [3:0]         lane_be_n;
  logic [31:0]        lane_wdata;
  logic [31:0]        lane_ld;

  // In IDLE the lane logic looks at the incoming request so byte enables
  // and store data are ready at acceptance; afterwards it uses the
  // registered request so the bus may change freely.
  assign lane_mode = (state_q == S_IDLE) ? bus.mem_mode  : mode_q;
  assign lane_off  = (state_q == S_IDLE) ? bus.addr[1:0] : boff_q;

  mem_byte_lane u_lane (
    .mode      (lane_mode),
    .boff      (lane_off),
    .wdata     (bus.wdata),
    .rword     (sram_dq_i),
    .be_n      (lane_be_n),
    .wdata_out (lane_wdata),
    .ld_data   (lane_ld)
  );

  // Next-state and next-output computation for the access sequencer
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    boff_d  = boff_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    aerr_d  = 1'b0;
    saddr_d = saddr_q;
    dq_o_d  = dq_o_q;
    dq_oe_d = dq_oe_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    be_n_d  = be_n_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req && is_access(bus.mem_mode)) begin
          mode_d = bus.mem_mode;
          boff_d = bus.addr[1:0];
          busy_d = 1'b1;
          if (is_word(bus.mem_mode) && (bus.addr[1:0] != 2'b00)) begin
            // Misaligned word access: report and finish without touching the SRAM
            aerr_d  = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            saddr_d = bus.addr[SRAM_AW+1:2];
            ce_n_d  = 1'b0;
            be_n_d  = lane_be_n;
            if (is_read(bus.mem_mode)) begin
              oe_n_d  = 1'b0;
              cnt_d   = WAIT_LD;
              state_d = S_RD;
            end else begin
              dq_o_d  = lane_wdata;
              dq_oe_d = 1'b1;
              state_d = S_WR_SETUP;
            end
          end
        end
      end
      S_RD: begin
        if (cnt_q == 4'd0) begin
          rdata_d = lane_ld;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          be_n_d  = BE_NONE;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR_SETUP: begin
        we_n_d  = 1'b0;
        cnt_d   = WAIT_LD;
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt_q == 4'd0) begin
          we_n_d  = 1'b1;
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR_HOLD: begin
        ce_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        be_n_d  = BE_NONE;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered pad/CPU outputs; reset aborts any access at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= IO_NOP;
      boff_q  <= 2'b00;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      aerr_q  <= 1'b0;
      saddr_q <= '0;
      dq_o_q  <= 32'h0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= BE_NONE;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      boff_q  <= boff_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      aerr_q  <= aerr_d;
      saddr_q <= saddr_d;
      dq_o_q  <= dq_o_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.align_err = aerr_q;
  assign sram_addr     = saddr_q;
  assign sram_dq_o     = dq_o_q;
  assign sram_dq_oe    = dq_oe_q;
  assign sram_ce_n     = ce_n_q;
  assign sram_oe_n     = oe_n_q;
  assign sram_we_n     = we_n_q;
  assign sram_be_n     = be_n_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed cases plus randomized accesses against a
// word-array reference memory, with pad-level strobe timing checks.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int W  = 1;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_dq_o, sram_dq_i;
  logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]    sram_be_n;

  logic [31:0]   sram_mem [0:1023];
  logic [31:0]   ref_mem  [0:1023];
  logic [31:0]   model_rdata;
  int            total = 0;
  int            bad   = 0;

  mem_responder_if bus();

  mem_responder #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_oe (sram_dq_oe),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_be_n  (sram_be_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM pin model
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[9:0]] : 32'h0BAD_F00D;

  always @(posedge clk)
    if (rst_n && !sram_ce_n && !sram_we_n && sram_dq_oe)
      for (int i = 0; i < 4; i++)
        if (!sram_be_n[i]) sram_mem[sram_addr[9:0]][8*i +: 8] <= sram_dq_o[8*i +: 8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference load result from the architectural memory image
  function automatic logic [31:0] ref_load(input logic [3:0] m, input logic [31:0] a);
    logic [31:0] w;
    int unsigned b;
    w = ref_mem[a[11:2]];
    if (m == IO_LW) return w;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
  endfunction

  task automatic ref_store(input logic [3:0] m, input logic [31:0] a, input logic [31:0] wd);
    int sh;
    if (m == IO_SW) ref_mem[a[11:2]] = wd;
    else begin
      sh = 8 * (a % 4);
      ref_mem[a[11:2]] = (ref_mem[a[11:2]] & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end
  endtask

  // One complete access with protocol observation at every falling edge
  task automatic txn(input logic [3:0] m, input logic [31:0] a, input logic [31:0] wd);
    logic [3:0]  be_tab [4];
    bit          misal, rd;
    int          k, exp_lat, ce_low, oe_low, we_low, first_we, gap, clash, addr_bad;
    logic [3:0]  be_seen;
    logic [31:0] dq_seen, exp_dq;
    bit          setup_ok, hold_ok;
    be_tab = '{4'hE, 4'hD, 4'hB, 4'h7};
    misal  = (m == IO_LW || m == IO_SW) && (a % 4 != 0);
    rd     = (m == IO_LW || m == IO_LB);
    exp_lat = misal ? 1 : (rd ? W + 2 : W + 4);
    k = 0; ce_low = 0; oe_low = 0; we_low = 0; first_we = 0; gap = 0; clash = 0; addr_bad = 0;
    be_seen = 4'hF; dq_seen = 32'h0; setup_ok = 0; hold_ok = 0;
    @(negedge clk);
    bus.req = 1'b1; bus.mem_mode = m; bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    #1;
    bus.req = 1'b0; bus.mem_mode = 4'($urandom_range(0, 15));
    bus.addr = $urandom; bus.wdata = $urandom;
    do begin
      @(negedge clk);
      k++;
      if (!bus.busy) gap++;
      if (!sram_ce_n) begin
        ce_low++;
        if (sram_addr !== a[AW+1:2]) addr_bad++;
      end
      if (!sram_oe_n) oe_low++;
      if (!sram_we_n) begin
        we_low++;
        if (first_we == 0) first_we = k;
        be_seen = sram_be_n; dq_seen = sram_dq_o;
      end
      if (sram_dq_oe && !sram_oe_n) clash++;
      if (k == 1)     setup_ok = sram_we_n && !sram_ce_n && sram_dq_oe;
      if (k == W + 3) hold_ok  = sram_we_n && !sram_ce_n && sram_dq_oe;
    end while (!bus.done && k < 40);
    if (!misal) begin
      if (rd) model_rdata = ref_load(m, a);
      else    ref_store(m, a, wd);
    end
    chk("done_latency", k, exp_lat);
    chk("align_err", bus.align_err, misal);
    chk("busy_contig", gap, 0);
    chk("rdata", bus.rdata, model_rdata);
    chk("oe_dq_clash", clash, 0);
    chk("addr_held", addr_bad, 0);
    if (misal) chk("misal_ce_quiet", ce_low, 0);
    else if (rd) begin
      chk("rd_oe_cycles", oe_low, W + 1);
      chk("rd_we_quiet", we_low, 0);
    end else begin
      exp_dq = (m == IO_SB) ? {4{wd[7:0]}} : wd;
      chk("wr_we_cycles", we_low, W + 1);
      chk("wr_we_first", first_we, 2);
      chk("wr_setup", setup_ok, 1);
      chk("wr_hold", hold_ok, 1);
      chk("wr_be_n", be_seen, (m == IO_SB) ? be_tab[a % 4] : 4'h0);
      chk("wr_dq_o", dq_seen, exp_dq);
    end
    @(negedge clk);
    chk("done_pulse", bus.done, 0);
    chk("busy_clear", bus.busy, 0);
    chk("aerr_pulse", bus.align_err, 0);
  endtask

  // A request carrying NOP or an undefined code must be ignored
  task automatic nop_req(input logic [3:0] m);
    @(negedge clk);
    bus.req = 1'b1; bus.mem_mode = m; bus.addr = $urandom & 32'hFFC;
    repeat (3) begin
      @(negedge clk);
      chk("nop_busy", bus.busy, 0);
      chk("nop_ce_n", sram_ce_n, 1);
    end
    bus.req = 1'b0;
  endtask

  initial begin
    logic [3:0]  mtab [4];
    logic [3:0]  m;
    logic [31:0] a;
    int          k, dn, ph, wi, off;
    bit          inr, eb, ed;
    mtab = '{IO_LW, IO_LB, IO_SW, IO_SB};
    rst_n = 1'b1;
    bus.req = 1'b0; bus.mem_mode = IO_NOP; bus.addr = 32'h0; bus.wdata = 32'h0;
    for (int i = 0; i < 1024; i++) begin
      a = $urandom;
      sram_mem[i] = a; ref_mem[i] = a;
    end
    sram_mem[10'h100] = 32'h8899_AABB; ref_mem[10'h100] = 32'h8899_AABB;

    // Asynchronous reset, checked before any clock edge
    #1 rst_n = 1'b0;
    #1;
    model_rdata = 32'h0;
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_aerr", bus.align_err, 0);
    chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("rst_be_n", sram_be_n, 4'hF);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dq_o", sram_dq_o, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed loads and stores
    txn(IO_LW, 32'h400, 32'h0);        chk("lw_400", bus.rdata, 32'h8899_AABB);
    txn(IO_LB, 32'h401, 32'h0);        chk("lb_401", bus.rdata, 32'hFFFF_FFAA);
    txn(IO_LB, 32'h403, 32'h0);        chk("lb_403", bus.rdata, 32'hFFFF_FF88);
    txn(IO_SB, 32'h402, 32'h1234_5655);
    txn(IO_LW, 32'h400, 32'h0);        chk("lw_after_sb", bus.rdata, 32'h8855_AABB);
    txn(IO_SB, 32'h400, 32'h0000_007F);
    txn(IO_LB, 32'h400, 32'h0);        chk("lb_pos", bus.rdata, 32'h0000_007F);
    txn(IO_SW, 32'h006, 32'h1111_1111);chk("misal_rdata", bus.rdata, 32'h0000_007F);
    txn(IO_SW, 32'h004, 32'hDEAD_BEEF);
    txn(IO_LW, 32'h004, 32'h0);        chk("lw_004", bus.rdata, 32'hDEAD_BEEF);
    txn(IO_LW, 32'h402, 32'h0);

    nop_req(IO_NOP);
    nop_req(4'd9);

    // Held request: re-acceptance only in the cycle after DONE
    @(negedge clk);
    bus.req = 1'b1; bus.mem_mode = IO_LW; bus.addr = 32'h400; dn = 0;
    for (int i = 1; i <= 3 * (W + 3) + 2; i++) begin
      @(negedge clk);
      ph  = (i - 1) % (W + 3);
      inr = (i <= 3 * (W + 3) - 1);
      eb  = inr && (ph < W + 2);
      ed  = inr && (ph == W + 1);
      chk("b2b_busy", bus.busy, eb);
      chk("b2b_done", bus.done, ed);
      if (bus.done) begin
        dn++;
        chk("b2b_rdata", bus.rdata, ref_load(IO_LW, 32'h400));
        if (dn >= 3) bus.req = 1'b0;
      end
    end
    bus.req = 1'b0;
    model_rdata = ref_load(IO_LW, 32'h400);

    // Reset in the middle of a write strobe
    @(negedge clk);
    bus.req = 1'b1; bus.mem_mode = IO_SW; bus.addr = 32'h800; bus.wdata = $urandom;
    @(posedge clk);
    #1 bus.req = 1'b0;
    k = 0;
    while (sram_we_n && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("rst_mid_reach_pulse", sram_we_n, 0);
    #1 rst_n = 1'b0;
    #1;
    model_rdata = 32'h0;
    chk("rst_mid_we_n", sram_we_n, 1);
    chk("rst_mid_ce_n", sram_ce_n, 1);
    chk("rst_mid_dq_oe", sram_dq_oe, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_done", bus.done, 0);
    chk("rst_mid_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    txn(IO_LW, 32'h400, 32'h0);

    // Randomized traffic over words 0..0x1FF
    for (int n = 0; n < 40; n++) begin
      wi = $urandom_range(0, 511);
      case ($urandom_range(0, 9))
        0: nop_req($urandom_range(0, 1) ? IO_NOP : 4'($urandom_range(5, 15)));
        1: begin
          a = 32'(wi) * 4 + 32'($urandom_range(1, 3));
          txn($urandom_range(0, 1) ? IO_LW : IO_SW, a, $urandom);
        end
        default: begin
          m   = mtab[$urandom_range(0, 3)];
          off = (m == IO_LB || m == IO_SB) ? $urandom_range(0, 3) : 0;
          a   = 32'(wi) * 4 + 32'(off);
          txn(m, a, $urandom);
        end
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
